hazard_ctrl_v: RTL and testbench
================================

Name: hazard_ctrl_v

Overview:
- Parametrised successor to the combinational hazard detection unit.
- Adds registered load-use stall sequencing for multi-cycle loads (LOAD_LAT), taken-branch flush control, and separate forwA/forwB selects.
- Adds a stall-on-any-RAW fallback when forwarding is compiled off.
- Sits beside the ID/EX pipeline registers. Drives PC/IF-ID hold, ID/EX bubble insertion and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- FORWARDING_ON, 1, 1 = EX/MEM and MEM/WB forwarding with load-use stall; 0 = stall on every RAW.
- LOAD_LAT, 1, total stall cycles per load-use hazard (range 1..7).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- idex_rs1, idex_rs2, idex_rd  in  REG_AW  ID/EX register fields
- idex_memRead, idex_regWrite  in  1  ID/EX control bits
- exmem_rd  in  REG_AW  EX/MEM destination register
- exmem_regWrite  in  1  EX/MEM write enable
- memwb_rd  in  REG_AW  MEM/WB destination register
- memwb_regWrite  in  1  MEM/WB write enable
- br_taken  in  1  taken branch/jump resolved in EX this cycle
- forwA, forwB  out  2  operand select: 00 = regfile, 01 = EX/MEM, 10 = MEM/WB
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush_ifid, flush_idex  out  1  squash IF/ID and ID/EX contents

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0.
  - Combinational outputs evaluate with state=IDLE; with all inputs 0, every output is 0.
- Forwarding (combinational, FORWARDING_ON=1):
  - forwA=01 if exmem_regWrite && exmem_rd!=0 && exmem_rd==idex_rs1.
  - else forwA=10 if memwb_regWrite && memwb_rd!=0 && memwb_rd==idex_rs1.
  - else forwA=00.
  - forwB: identical rule against idex_rs2. The two selects are fully independent.
  - EX/MEM has priority over MEM/WB.
  - With FORWARDING_ON=0, forwA=forwB=00 always.
- RAW match per source s in {rs1, rs2}: id_use_s && id_s!=0 && id_s==stage_rd && stage_regWrite.
- Hazard detection:
  - FORWARDING_ON=1: ld_haz = idex_memRead && RAW match against idex_rd for either source.
  - FORWARDING_ON=0: raw_haz = RAW match against any of idex, exmem or memwb for either source. stall=raw_haz combinationally; the FSM stays IDLE.
- FSM (FORWARDING_ON=1), states IDLE and LD_STALL, cnt width 3 bits:
  - IDLE, ld_haz && !br_taken: stall=1 this cycle.
    - LOAD_LAT=1: stay IDLE.
    - LOAD_LAT>1: cnt<=LOAD_LAT-1, next state LD_STALL.
  - LD_STALL: stall=1 independent of inputs. cnt decrements each cycle; when cnt==1, next state is IDLE.
  - Total stall per hazard is exactly LOAD_LAT consecutive cycles.
  - A fresh ld_haz in the first IDLE cycle after LD_STALL restarts the sequence normally.
- Branch:
  - br_taken=1 gives flush_ifid=flush_idex=1 in the same cycle, stall=0.
  - In LD_STALL it also forces state<=IDLE and cnt<=0 (branch wins over any stall).
- Flush outputs are combinational and last only while br_taken is high. No internal flush timer.
- Reset asserted mid-stall: immediate return to IDLE and stall=0 (given inputs inactive).

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flushes[31:0], reset to 0.
  - perf_stall_cycles increments on each cycle with stall=1.
  - perf_flushes increments on each cycle with br_taken=1.
  - Both counters saturate at 32'hFFFFFFFF and do not wrap.
- When undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Forwarding: exmem_rd=5, exmem_regWrite=1, memwb_rd=5, memwb_regWrite=1, idex_rs1=5, idex_rs2=5 -> forwA=01, forwB=01. Then exmem_rd=0 -> both 10. Then memwb_regWrite=0 -> both 00.
- Split forwarding: idex_rs1=3 (exmem_rd=3), idex_rs2=7 (memwb_rd=7) -> forwA=01, forwB=10.
- Load-use, LOAD_LAT=3: idex_memRead=1, idex_rd=4, id_rs2=4, id_use_rs2=1 for one cycle, then inputs cleared -> stall high exactly 3 cycles, then 0.
- No false stall: same hazard with id_use_rs2=0, or with idex_rd=0 -> stall=0.
- Branch during stall, LOAD_LAT=4: br_taken=1 in the 2nd stall cycle -> that cycle stall=0, flush_ifid=flush_idex=1; next cycle stall=0, state IDLE.
- FORWARDING_ON=0: memwb_rd=9, memwb_regWrite=1, id_rs1=9, id_use_rs1=1 -> stall=1, forwA=00. Async rst_n low mid-LD_STALL -> stall=0 immediately.
- HAZARD_PERF_EN: the LOAD_LAT=3 hazard followed by 2 br_taken pulses -> perf_stall_cycles=3, perf_flushes=2.

Source files
------------

// File: rtl/hazard_ctrl_v.sv
// Hazard unit for the ID/EX boundary: operand forwarding, load-use stall sequencing and branch flush.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no stall in progress; stall follows the live load-use check
//   LD_STALL | holding for the remaining LOAD_LAT-1 cycles of a load-use stall
module hazard_ctrl_v #(
  parameter int REG_AW        = 5,
  parameter int FORWARDING_ON = 1,
  parameter int LOAD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memRead,
  input  logic              idex_regWrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regWrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regWrite,
  input  logic              br_taken,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushes
`endif
);

  typedef enum logic {IDLE, LD_STALL} state_t;

  localparam logic       FWD_ON = (FORWARDING_ON != 0);
  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;

  logic w_exmem_fwd_a, w_exmem_fwd_b, w_memwb_fwd_a, w_memwb_fwd_b;
  logic w_idex_raw, w_exmem_raw, w_memwb_raw;
  logic w_ld_haz, w_raw_haz, w_stall;

  function automatic logic raw_match(input logic use_s, input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] rd, input logic wr_en);
    return use_s && (src != '0) && (src == rd) && wr_en;
  endfunction

  assign w_exmem_fwd_a = exmem_regWrite && (exmem_rd != '0) && (exmem_rd == idex_rs1);
  assign w_exmem_fwd_b = exmem_regWrite && (exmem_rd != '0) && (exmem_rd == idex_rs2);
  assign w_memwb_fwd_a = memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs1);
  assign w_memwb_fwd_b = memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs2);

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  assign forwA = !FWD_ON       ? 2'b00 :
                 w_exmem_fwd_a ? 2'b01 :
                 w_memwb_fwd_a ? 2'b10 : 2'b00;
  assign forwB = !FWD_ON       ? 2'b00 :
                 w_exmem_fwd_b ? 2'b01 :
                 w_memwb_fwd_b ? 2'b10 : 2'b00;

  assign w_idex_raw  = raw_match(id_use_rs1, id_rs1, idex_rd, idex_regWrite) ||
                       raw_match(id_use_rs2, id_rs2, idex_rd, idex_regWrite);
  assign w_exmem_raw = raw_match(id_use_rs1, id_rs1, exmem_rd, exmem_regWrite) ||
                       raw_match(id_use_rs2, id_rs2, exmem_rd, exmem_regWrite);
  assign w_memwb_raw = raw_match(id_use_rs1, id_rs1, memwb_rd, memwb_regWrite) ||
                       raw_match(id_use_rs2, id_rs2, memwb_rd, memwb_regWrite);

  assign w_ld_haz  = FWD_ON && idex_memRead && w_idex_raw;
  assign w_raw_haz = w_idex_raw || w_exmem_raw || w_memwb_raw;

  // A taken branch squashes the dependent instruction, so it always overrides a stall.
  assign w_stall    = !br_taken && (FWD_ON ? ((r_state == LD_STALL) || w_ld_haz) : w_raw_haz);
  assign stall      = w_stall;
  assign flush_ifid = br_taken;
  assign flush_idex = br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ld_haz && !br_taken && (LOAD_LAT > 1)) begin
            r_cnt   <= LAT_M1;
            r_state <= LD_STALL;
          end
        end
        LD_STALL: begin
          if (br_taken || (r_cnt == 3'd1)) begin
            r_cnt   <= 3'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_cnt   <= 3'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
    end else begin
      if (w_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (br_taken && (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_v.sv
// Bench for hazard_ctrl_v: three builds (LOAD_LAT 3, LOAD_LAT 4, forwarding off) against a stall-budget model.
module tb_hazard_ctrl_v;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       id_use_rs1, id_use_rs2, idex_memRead, idex_regWrite;
  logic       exmem_regWrite, memwb_regWrite, br_taken;

  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic       st [3];
  logic       fi [3];
  logic       fx [3];
`ifdef HAZARD_PERF_EN
  logic [31:0] ps [3];
  logic [31:0] pf [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model: remaining stall cycles owed after the current one, and event counts
  int lat_k [3] = '{3, 4, 1};
  int fwd_k [3] = '{1, 1, 0};
  int left  [3];
  int m_ps  [3];
  int m_pf  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_v #(
      .REG_AW(5),
      .FORWARDING_ON((g == 2) ? 0 : 1),
      .LOAD_LAT((g == 0) ? 3 : ((g == 1) ? 4 : 1))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
      .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite),
      .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
      .br_taken(br_taken),
      .forwA(fa[g]), .forwB(fb[g]), .stall(st[g]),
      .flush_ifid(fi[g]), .flush_idex(fx[g])
`ifdef HAZARD_PERF_EN
      , .perf_stall_cycles(ps[g]), .perf_flushes(pf[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rm(input logic u, input logic [4:0] s, input logic [4:0] rd, input logic we);
    return u && (s != 0) && (s == rd) && we;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (exmem_regWrite && exmem_rd != 0 && exmem_rd == rs) return 2'b01;
    if (memwb_regWrite && memwb_rd != 0 && memwb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_in();
    {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {id_use_rs1, id_use_rs2, idex_memRead, idex_regWrite} = '0;
    {exmem_regWrite, memwb_regWrite, br_taken} = '0;
  endtask

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      left[k] = 0; m_ps[k] = 0; m_pf[k] = 0;
    end
  endtask

  // Check all builds against the model for the current inputs, then advance one clock.
  task automatic cycle(input string tag);
    logic ld, rawany, es;
    logic [1:0] ea, eb;
    #2;
    ld = idex_memRead && (rm(id_use_rs1, id_rs1, idex_rd, idex_regWrite) ||
                          rm(id_use_rs2, id_rs2, idex_rd, idex_regWrite));
    rawany = rm(id_use_rs1, id_rs1, idex_rd, idex_regWrite) || rm(id_use_rs2, id_rs2, idex_rd, idex_regWrite) ||
             rm(id_use_rs1, id_rs1, exmem_rd, exmem_regWrite) || rm(id_use_rs2, id_rs2, exmem_rd, exmem_regWrite) ||
             rm(id_use_rs1, id_rs1, memwb_rd, memwb_regWrite) || rm(id_use_rs2, id_rs2, memwb_rd, memwb_regWrite);
    for (int k = 0; k < 3; k++) begin
      if (fwd_k[k] != 0) begin
        es = !br_taken && (left[k] > 0 || ld);
        ea = fsel(idex_rs1);
        eb = fsel(idex_rs2);
      end else begin
        es = !br_taken && rawany;
        ea = 2'b00;
        eb = 2'b00;
      end
      chk($sformatf("%s/u%0d/stall", tag, k), 32'(st[k]), 32'(es));
      chk($sformatf("%s/u%0d/forwA", tag, k), 32'(fa[k]), 32'(ea));
      chk($sformatf("%s/u%0d/forwB", tag, k), 32'(fb[k]), 32'(eb));
      chk($sformatf("%s/u%0d/flush_ifid", tag, k), 32'(fi[k]), 32'(br_taken));
      chk($sformatf("%s/u%0d/flush_idex", tag, k), 32'(fx[k]), 32'(br_taken));
      if (rst_n) begin
        if (es) m_ps[k]++;
        if (br_taken) m_pf[k]++;
        if (br_taken) left[k] = 0;
        else if (left[k] > 0) left[k]--;
        else if (ld && fwd_k[k] != 0) left[k] = lat_k[k] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs2();
    clear_in();
    idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 5'd4;
    id_rs2 = 5'd4; id_use_rs2 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    reset_model();
    #1;
    cycle("reset");
    rst_n = 1'b1;
    cycle("idle");

    // forwarding priority and fallback
    exmem_rd = 5'd5; exmem_regWrite = 1'b1; memwb_rd = 5'd5; memwb_regWrite = 1'b1;
    idex_rs1 = 5'd5; idex_rs2 = 5'd5;
    #1; chk("fwd_exmem_a", 32'(fa[0]), 32'd1); chk("fwd_exmem_b", 32'(fb[0]), 32'd1);
    cycle("fwd_exmem");
    exmem_rd = 5'd0;
    #1; chk("fwd_memwb_a", 32'(fa[0]), 32'd2); chk("fwd_memwb_b", 32'(fb[0]), 32'd2);
    cycle("fwd_memwb");
    memwb_regWrite = 1'b0;
    #1; chk("fwd_none_a", 32'(fa[0]), 32'd0); chk("fwd_none_b", 32'(fb[0]), 32'd0);
    cycle("fwd_none");

    // split forwarding
    clear_in();
    idex_rs1 = 5'd3; exmem_rd = 5'd3; exmem_regWrite = 1'b1;
    idex_rs2 = 5'd7; memwb_rd = 5'd7; memwb_regWrite = 1'b1;
    #1; chk("split_a", 32'(fa[0]), 32'd1); chk("split_b", 32'(fb[0]), 32'd2);
    cycle("split");

    // load-use, LOAD_LAT=3 on u0
    load_use_rs2();
    #1; chk("ld3_c0", 32'(st[0]), 32'd1);
    cycle("ld3_c0");
    clear_in();
    #1; chk("ld3_c1", 32'(st[0]), 32'd1);
    cycle("ld3_c1");
    #1; chk("ld3_c2", 32'(st[0]), 32'd1);
    cycle("ld3_c2");
    #1; chk("ld3_c3", 32'(st[0]), 32'd0);
    cycle("ld3_c3");
    repeat (2) cycle("drain");

    // no false stall
    load_use_rs2(); id_use_rs2 = 1'b0;
    #1; chk("nouse", 32'(st[0]), 32'd0);
    cycle("nouse");
    load_use_rs2(); idex_rd = 5'd0; id_rs2 = 5'd0;
    #1; chk("rd0", 32'(st[0]), 32'd0);
    cycle("rd0");

    // branch in 2nd stall cycle, LOAD_LAT=4 on u1
    load_use_rs2();
    cycle("br_c0");
    clear_in(); br_taken = 1'b1;
    #1; chk("br_stall", 32'(st[1]), 32'd0); chk("br_fifid", 32'(fi[1]), 32'd1); chk("br_fidex", 32'(fx[1]), 32'd1);
    cycle("br_c1");
    clear_in();
    #1; chk("br_after", 32'(st[1]), 32'd0);
    cycle("br_c2");

    // stall on any RAW when forwarding is off
    clear_in();
    memwb_rd = 5'd9; memwb_regWrite = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1; chk("nofwd_stall", 32'(st[2]), 32'd1); chk("nofwd_forwA", 32'(fa[2]), 32'd0);
    cycle("nofwd");

    // async reset in the middle of LD_STALL
    load_use_rs2();
    cycle("rst_c0");
    clear_in();
    #1; chk("rst_pre", 32'(st[0]), 32'd1);
    rst_n = 1'b0;
    #1; chk("rst_u0", 32'(st[0]), 32'd0); chk("rst_u1", 32'(st[1]), 32'd0);
    reset_model();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // event counters: one LOAD_LAT=3 hazard then two branch pulses
    load_use_rs2();
    cycle("perf_ld");
    clear_in();
    repeat (3) cycle("perf_gap");
    br_taken = 1'b1; cycle("perf_br1");
    br_taken = 1'b0; cycle("perf_gap");
    br_taken = 1'b1; cycle("perf_br2");
    br_taken = 1'b0; cycle("perf_gap");
`ifdef HAZARD_PERF_EN
    chk("perf_stall_u0", ps[0], 32'd3);
    chk("perf_flush_u0", pf[0], 32'd2);
    chk("perf_stall_u1", ps[1], 32'd4);
`endif

    // randomized traffic with a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));    id_rs2 = 5'($urandom_range(0, 3));
      idex_rs1 = 5'($urandom_range(0, 3));  idex_rs2 = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3));   exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);  id_use_rs2 = 1'($urandom);
      idex_memRead = 1'($urandom); idex_regWrite = 1'($urandom);
      exmem_regWrite = 1'($urandom); memwb_regWrite = 1'($urandom);
      br_taken = ($urandom_range(0, 7) == 0);
      cycle($sformatf("rand%0d", i));
    end
`ifdef HAZARD_PERF_EN
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("perf_stall_end_u%0d", k), ps[k], 32'(m_ps[k]));
      chk($sformatf("perf_flush_end_u%0d", k), pf[k], 32'(m_pf[k]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
